// File: rtl/vend_pkg.sv
// Shared constants and types for the vending-machine timer scheduler.
package vend_pkg;

    localparam int unsigned CLK_HZ_DEF = 40000000;

    // Timer channel assignments used by the machine's FSM blocks
    localparam int unsigned CH_DISPENSE = 0;
    localparam int unsigned CH_CHANGE   = 1;
    localparam int unsigned CH_IDLE     = 2;
    localparam int unsigned CH_DISPLAY  = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } sweep_state_t;

endpackage

// File: rtl/vend_tick_gen.sv
// Timebase: quarter-second prescaler, blink square waves and the 1 Hz event.
module vend_tick_gen
    import vend_pkg::*;
#(
    parameter int unsigned CLK_HZ = CLK_HZ_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_sec_evt_c,
    output logic o_tick_1hz,
    output logic o_blink_2hz,
    output logic o_blink_1hz
);

    localparam int unsigned QTR   = CLK_HZ / 4;
    localparam int unsigned PRE_W = (QTR > 1) ? $clog2(QTR) : 1;

    logic [PRE_W-1:0] r_presc;
    logic [1:0]       r_qtr;
    logic             r_tick;
    logic             r_blink_2hz;
    logic             r_blink_1hz;
    logic             w_qtick;

    assign w_qtick     = (r_presc == PRE_W'(QTR - 1));
    // Second boundary: the quarter tick that wraps the quarter counter 3->0
    assign o_sec_evt_c = w_qtick && (r_qtr == 2'd3);

    // Prescaler, quarter counter and blink/tick registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_presc     <= '0;
            r_qtr       <= '0;
            r_tick      <= 1'b0;
            r_blink_2hz <= 1'b0;
            r_blink_1hz <= 1'b0;
        end else begin
            r_tick <= o_sec_evt_c;
            if (w_qtick) begin
                r_presc     <= '0;
                r_qtr       <= r_qtr + 2'd1;
                r_blink_2hz <= ~r_blink_2hz;
                // Odd quarter count means this tick wraps 1->2 or 3->0
                if (r_qtr[0]) begin
                    r_blink_1hz <= ~r_blink_1hz;
                end
            end else begin
                r_presc <= r_presc + PRE_W'(1);
            end
        end
    end

    assign o_tick_1hz  = r_tick;
    assign o_blink_2hz = r_blink_2hz;
    assign o_blink_1hz = r_blink_1hz;

endmodule

// File: rtl/vend_timer_sched.sv
// Countdown timer array swept once per second by a shared decrementer.
module vend_timer_sched
    import vend_pkg::*;
#(
    parameter int unsigned CLK_HZ = CLK_HZ_DEF,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned SEC_W  = 6,
    localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk_in,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       cancel,
    input  logic [NUM_CH*SEC_W-1:0] load_sec,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       done,
    input  logic [SEL_W-1:0]        rd_sel,
    output logic [SEC_W-1:0]        rd_sec,
    output logic                    tick_1hz,
    output logic                    blink_2hz,
    output logic                    blink_1hz
);

    logic [SEC_W-1:0]  r_count [NUM_CH];
    logic [NUM_CH-1:0] r_busy;
    logic [NUM_CH-1:0] r_done;
    logic [SEC_W-1:0]  r_rd_sec;
    sweep_state_t      r_state;
    sweep_state_t      w_state_nxt;
    logic [SEL_W-1:0]  r_idx;
    logic [SEL_W-1:0]  w_idx_nxt;
    logic              w_sec_evt;

    vend_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_gen (
        .i_clk       (clk_in),
        .i_rst_n     (rst_n),
        .o_sec_evt_c (w_sec_evt),
        .o_tick_1hz  (tick_1hz),
        .o_blink_2hz (blink_2hz),
        .o_blink_1hz (blink_1hz)
    );

    // Sweep FSM state and channel index registers
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Sweep FSM next state: one channel per cycle after each 1 Hz event
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (w_sec_evt) begin
                    w_state_nxt = ST_SWEEP;
                    w_idx_nxt   = '0;
                end
            end
            ST_SWEEP: begin
                if (r_idx == SEL_W'(NUM_CH - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + SEL_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Channel counters: cancel beats start, start beats the sweep update
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_count[i] <= '0;
            end
            r_busy <= '0;
            r_done <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_done[i] <= 1'b0;
                if (cancel[i]) begin
                    r_count[i] <= '0;
                    r_busy[i]  <= 1'b0;
                end else if (start[i]) begin
                    // A zero load expires immediately without ever going busy
                    r_count[i] <= load_sec[i*SEC_W +: SEC_W];
                    r_busy[i]  <= |load_sec[i*SEC_W +: SEC_W];
                    r_done[i]  <= ~|load_sec[i*SEC_W +: SEC_W];
                end else if ((r_state == ST_SWEEP) && (r_idx == SEL_W'(i)) && r_busy[i]) begin
                    if (r_count[i] <= SEC_W'(1)) begin
                        r_count[i] <= '0;
                        r_busy[i]  <= 1'b0;
                        r_done[i]  <= 1'b1;
                    end else begin
                        r_count[i] <= r_count[i] - SEC_W'(1);
                    end
                end
            end
        end
    end

    // Registered remaining-time read port; unused selects read as zero
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_rd_sec <= '0;
        end else if (32'(rd_sel) < NUM_CH) begin
            r_rd_sec <= r_count[rd_sel];
        end else begin
            r_rd_sec <= '0;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign rd_sec = r_rd_sec;

endmodule

// File: tb/tb_vend_timer_sched.sv
// Directed bench for vend_timer_sched with a fast timebase (CLK_HZ=16).
module tb_vend_timer_sched;
    import vend_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic [3:0]  start;
    logic [3:0]  cancel;
    logic [23:0] load_sec;
    logic [3:0]  busy;
    logic [3:0]  done;
    logic [1:0]  rd_sel;
    logic [5:0]  rd_sec;
    logic        tick_1hz;
    logic        blink_2hz;
    logic        blink_1hz;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;
    int unsigned done_cnt [4] = '{0, 0, 0, 0};
    int unsigned coincide = 0;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  st;
        logic [3:0]  cn;
        logic [23:0] ld;
        logic [1:0]  sel;
        logic [3:0]  busy;
        logic [3:0]  done;
        logic [5:0]  rsec;
    } vec_t;

    vec_t vecs[$];

    vend_timer_sched #(
        .CLK_HZ (16),
        .NUM_CH (4),
        .SEC_W  (6)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .start     (start),
        .cancel    (cancel),
        .load_sec  (load_sec),
        .busy      (busy),
        .done      (done),
        .rd_sel    (rd_sel),
        .rd_sec    (rd_sec),
        .tick_1hz  (tick_1hz),
        .blink_2hz (blink_2hz),
        .blink_1hz (blink_1hz)
    );

    always #5 clk_in = ~clk_in;

    // Count every done pulse and any cycle with more than one done high
    always @(posedge clk_in) begin
        for (int i = 0; i < 4; i++) begin
            if (done[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
        end
        if ($countones(done) > 1) coincide <= coincide + 1;
    end

    function automatic vec_t mk(input int unsigned c, input logic [3:0] st, input logic [3:0] cn,
                                input logic [23:0] ld, input logic [1:0] sel, input logic [3:0] b,
                                input logic [3:0] d, input logic [5:0] rs);
        vec_t v;
        v.cyc = c; v.st = st; v.cn = cn; v.ld = ld; v.sel = sel;
        v.busy = b; v.done = d; v.rsec = rs;
        return v;
    endfunction

    function automatic logic [23:0] ld4(input logic [5:0] c3, input logic [5:0] c2,
                                        input logic [5:0] c1, input logic [5:0] c0);
        return {c3, c2, c1, c0};
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    // One clock edge; returns at the following falling edge for sampling/driving
    task automatic step();
        @(posedge clk_in);
        cyc++;
        @(negedge clk_in);
    endtask

    initial begin
        logic [1:0] s_dsp, s_chg, s_idl, s_dis;
        s_dsp = 2'(CH_DISPENSE);
        s_chg = 2'(CH_CHANGE);
        s_idl = 2'(CH_IDLE);
        s_dis = 2'(CH_DISPLAY);

        rst_n = 1'b0; start = '0; cancel = '0; load_sec = '0; rd_sel = '0;

        // Cycle numbers count edges after reset release; ticks land on multiples of 16
        vecs.push_back(mk(65,  4'b0001, 4'b0000, ld4(0, 0, 0, 3), s_dsp, 4'b0001, 4'b0000, 0));
        vecs.push_back(mk(66,  4'b0000, 4'b0000, '0,              s_dsp, 4'b0001, 4'b0000, 3));
        vecs.push_back(mk(82,  4'b0000, 4'b0000, '0,              s_dsp, 4'b0001, 4'b0000, 2));
        vecs.push_back(mk(98,  4'b0000, 4'b0000, '0,              s_dsp, 4'b0001, 4'b0000, 1));
        vecs.push_back(mk(112, 4'b0000, 4'b0000, '0,              s_dsp, 4'b0001, 4'b0000, 1));
        vecs.push_back(mk(113, 4'b0000, 4'b0000, '0,              s_dsp, 4'b0000, 4'b0001, 1));
        vecs.push_back(mk(114, 4'b0000, 4'b0000, '0,              s_dsp, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(120, 4'b0110, 4'b0000, ld4(0, 2, 2, 0), s_chg, 4'b0110, 4'b0000, 0));
        vecs.push_back(mk(121, 4'b0000, 4'b0000, '0,              s_chg, 4'b0110, 4'b0000, 2));
        vecs.push_back(mk(131, 4'b0000, 4'b0000, '0,              s_chg, 4'b0110, 4'b0000, 1));
        vecs.push_back(mk(145, 4'b0000, 4'b0000, '0,              s_idl, 4'b0110, 4'b0000, 1));
        vecs.push_back(mk(146, 4'b0000, 4'b0000, '0,              s_idl, 4'b0100, 4'b0010, 1));
        vecs.push_back(mk(147, 4'b0000, 4'b0000, '0,              s_idl, 4'b0000, 4'b0100, 1));
        vecs.push_back(mk(148, 4'b0000, 4'b0000, '0,              s_idl, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(150, 4'b1000, 4'b0000, ld4(0, 0, 0, 0), s_dis, 4'b0000, 4'b1000, 0));
        vecs.push_back(mk(151, 4'b0000, 4'b0000, '0,              s_dis, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(152, 4'b0100, 4'b0000, ld4(0, 5, 0, 0), s_idl, 4'b0100, 4'b0000, 0));
        vecs.push_back(mk(153, 4'b0000, 4'b0000, '0,              s_idl, 4'b0100, 4'b0000, 5));
        vecs.push_back(mk(163, 4'b0100, 4'b0100, ld4(0, 9, 0, 0), s_idl, 4'b0000, 4'b0000, 5));
        vecs.push_back(mk(164, 4'b0000, 4'b0000, '0,              s_idl, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(166, 4'b0000, 4'b0000, '0,              s_idl, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(180, 4'b0010, 4'b0000, ld4(0, 0, 4, 0), s_chg, 4'b0010, 4'b0000, 0));
        vecs.push_back(mk(181, 4'b0000, 4'b0000, '0,              s_chg, 4'b0010, 4'b0000, 4));
        vecs.push_back(mk(193, 4'b0000, 4'b0000, '0,              s_chg, 4'b0010, 4'b0000, 4));

        // Reset holds every output low
        @(negedge clk_in);
        step(); step(); step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rd_sec", 32'(rd_sec), 0);
        chk("rst_tick", 32'(tick_1hz), 0);
        chk("rst_blink2", 32'(blink_2hz), 0);
        chk("rst_blink1", 32'(blink_1hz), 0);

        // Free-running timebase for 64 cycles after release
        rst_n = 1'b1;
        cyc = 0;
        for (int n = 1; n <= 64; n++) begin
            step();
            chk("tick_1hz", 32'(tick_1hz), ((n % 16) == 0) ? 1 : 0);
            chk("blink_2hz", 32'(blink_2hz), (n / 4) % 2);
            chk("blink_1hz", 32'(blink_1hz), (n / 8) % 2);
        end

        // Table-driven timer scenarios
        foreach (vecs[k]) begin
            while (cyc < vecs[k].cyc - 1) step();
            start    = vecs[k].st;
            cancel   = vecs[k].cn;
            load_sec = vecs[k].ld;
            rd_sel   = vecs[k].sel;
            step();
            start = '0; cancel = '0; load_sec = '0;
            chk($sformatf("v%0d_busy", k), 32'(busy), 32'(vecs[k].busy));
            chk($sformatf("v%0d_done", k), 32'(done), 32'(vecs[k].done));
            chk($sformatf("v%0d_rd_sec", k), 32'(rd_sec), 32'(vecs[k].rsec));
        end

        // Reset on channel 1's sweep slot while it still holds 4
        rst_n = 1'b0;
        step();
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_rd_sec", 32'(rd_sec), 0);
        chk("midrst_tick", 32'(tick_1hz), 0);
        chk("midrst_blink2", 32'(blink_2hz), 0);
        chk("midrst_blink1", 32'(blink_1hz), 0);
        rst_n = 1'b1;
        cyc = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            chk("post_rst_tick", 32'(tick_1hz), (n == 16) ? 1 : 0);
            chk("post_rst_busy", 32'(busy), 0);
            chk("post_rst_rd_sec", 32'(rd_sec), 0);
        end

        // Every channel expired exactly once and no two expiries overlapped
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("done_cnt_ch%0d", i), done_cnt[i], 1);
        end
        chk("done_coincide", coincide, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
